// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding selects, load/branch/MDU stalls and MDU sequencing FSM.
// Define HAZARD_PERF_CNT_EN to build in saturating stall-cause counters.
module hazard_ctrl #(
  parameter int MDU_LATENCY = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic [4:0]       WriteRegM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MemtoRegM,
  input  logic             BranchD,
  input  logic             MduStartD,
  input  logic             MduReadD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushE,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MduBusy,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] LoadStallCnt,
  output logic [CNT_W-1:0] BranchStallCnt,
  output logic [CNT_W-1:0] MduStallCnt,
`endif
  output logic             MduDone
);

  localparam int LW = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;

  mdu_state_t    state_q;
  logic [LW-1:0] mdu_cnt_q;
  logic          busy_q;
  logic          done_q;

  logic lwstall;
  logic branchstall;
  logic mdustall;
  logic stall;

  // Register 0 is hardwired, so it never counts as a dependency.
  function automatic logic match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (match(src, WriteRegM) && RegWriteM)
      return 2'b10;
    else if (match(src, WriteRegW) && RegWriteW)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    ForwardAE = fwd_sel(RsE);
    ForwardBE = fwd_sel(RtE);
    ForwardAD = match(RsD, WriteRegM) && RegWriteM;
    ForwardBD = match(RtD, WriteRegM) && RegWriteM;

    lwstall     = MemtoRegE && (match(RtE, RsD) || match(RtE, RtD));
    branchstall = BranchD &&
                  ((RegWriteE && (match(WriteRegE, RsD) || match(WriteRegE, RtD))) ||
                   (MemtoRegM && (match(WriteRegM, RsD) || match(WriteRegM, RtD))));
    mdustall    = (MduStartD || MduReadD) && (state_q != IDLE);
    stall       = lwstall || branchstall || mdustall;

    StallF = stall;
    StallD = stall;
    FlushE = stall;
  end

  // Busy/done flags are registered alongside the state so they are glitch-free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mdu_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (MduStartD && !stall) begin
            state_q   <= BUSY;
            mdu_cnt_q <= LW'(MDU_LATENCY - 1);
            busy_q    <= 1'b1;
          end
        end
        BUSY: begin
          if (mdu_cnt_q == '0) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            mdu_cnt_q <= mdu_cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign MduBusy = busy_q;
  assign MduDone = done_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [2:0]       cause;
  logic [CNT_W-1:0] perf_q [3];

  assign cause = {mdustall, branchstall, lwstall};

  for (genvar gi = 0; gi < 3; gi++) begin : g_perf
    always_ff @(posedge clock or posedge reset) begin
      if (reset)
        perf_q[gi] <= '0;
      else if (cause[gi] && (perf_q[gi] != {CNT_W{1'b1}}))
        perf_q[gi] <= perf_q[gi] + 1'b1;
    end
  end

  assign LoadStallCnt   = perf_q[0];
  assign BranchStallCnt = perf_q[1];
  assign MduStallCnt    = perf_q[2];
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MDU_LATENCY=4; counters checked with CNT_W=2 when built in).
module tb_hazard_ctrl;

  localparam int LAT   = 4;
  localparam int CNT_W = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
  logic       BranchD, MduStartD, MduReadD;
  logic       StallF, StallD, FlushE, ForwardAD, ForwardBD, MduBusy, MduDone;
  logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] LoadStallCnt, BranchStallCnt, MduStallCnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  hazard_ctrl #(.MDU_LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .BranchD(BranchD), .MduStartD(MduStartD), .MduReadD(MduReadD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MduBusy(MduBusy),
`ifdef HAZARD_PERF_CNT_EN
    .LoadStallCnt(LoadStallCnt), .BranchStallCnt(BranchStallCnt), .MduStallCnt(MduStallCnt),
`endif
    .MduDone(MduDone)
  );

  task automatic clear_inputs();
    RsD = 0; RtD = 0; RsE = 0; RtE = 0;
    WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    MemtoRegE = 0; MemtoRegM = 0; BranchD = 0;
    MduStartD = 0; MduReadD = 0;
  endtask

  // Advance past the next rising edge and settle.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    total++;
    if ({MduBusy, MduDone, StallD, StallF, FlushE} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=00000", {MduBusy, MduDone, StallD, StallF, FlushE});
    end
    MemtoRegE = 1; RtE = 7; RsD = 7; #1;
    total++;
    if (StallD !== 1'b1) begin
      bad++;
      $display("FAIL reset_comb_follow got=%b want=1", StallD);
    end
    clear_inputs();
    reset = 1'b0;
    #1;
    $display("test_reset done");
  endtask

  task automatic test_forward();
    clear_inputs();
    RsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1; #1;
    total++;
    if (ForwardAE !== 2'b10) begin bad++; $display("FAIL fwd_ae_m got=%b want=10", ForwardAE); end
    WriteRegM = 0; #1;
    total++;
    if (ForwardAE !== 2'b01) begin bad++; $display("FAIL fwd_ae_w got=%b want=01", ForwardAE); end
    RsE = 0; #1;
    total++;
    if (ForwardAE !== 2'b00) begin bad++; $display("FAIL fwd_ae_r0 got=%b want=00", ForwardAE); end
    RtE = 9; WriteRegM = 9; RegWriteM = 0; WriteRegW = 9; RegWriteW = 1; #1;
    total++;
    if (ForwardBE !== 2'b01) begin bad++; $display("FAIL fwd_be_w got=%b want=01", ForwardBE); end
    RegWriteM = 1; #1;
    total++;
    if (ForwardBE !== 2'b10) begin bad++; $display("FAIL fwd_be_m got=%b want=10", ForwardBE); end
    RsD = 4; RtD = 9; WriteRegM = 9; #1;
    total++;
    if ({ForwardAD, ForwardBD} !== 2'b01) begin
      bad++; $display("FAIL fwd_d got=%b want=01", {ForwardAD, ForwardBD});
    end
    RsD = 0; RtD = 0; WriteRegM = 0; #1;
    total++;
    if ({ForwardAD, ForwardBD} !== 2'b00) begin
      bad++; $display("FAIL fwd_d_r0 got=%b want=00", {ForwardAD, ForwardBD});
    end
    $display("test_forward done");
  endtask

  task automatic test_load_stall();
    clear_inputs();
    MemtoRegE = 1; RtE = 8; RsD = 8; #1;
    total++;
    if ({StallF, StallD, FlushE} !== 3'b111) begin
      bad++; $display("FAIL lw_rs got=%b want=111", {StallF, StallD, FlushE});
    end
    RsD = 0; RtD = 8; #1;
    total++;
    if (StallD !== 1'b1) begin bad++; $display("FAIL lw_rt got=%b want=1", StallD); end
    RtE = 0; RtD = 0; #1;
    total++;
    if ({StallF, StallD, FlushE} !== 3'b000) begin
      bad++; $display("FAIL lw_r0 got=%b want=000", {StallF, StallD, FlushE});
    end
    MemtoRegE = 0; RtE = 8; RsD = 8; #1;
    total++;
    if (StallD !== 1'b0) begin bad++; $display("FAIL lw_noload got=%b want=0", StallD); end
    $display("test_load_stall done");
  endtask

  task automatic test_branch_stall();
    clear_inputs();
    BranchD = 1; RsD = 3; RegWriteE = 1; WriteRegE = 3; #1;
    total++;
    if (StallD !== 1'b1) begin bad++; $display("FAIL br_e got=%b want=1", StallD); end
    step();
    RegWriteE = 0; WriteRegE = 0; MemtoRegM = 1; WriteRegM = 3; #1;
    total++;
    if (StallD !== 1'b1) begin bad++; $display("FAIL br_m_load got=%b want=1", StallD); end
    step();
    MemtoRegM = 0; RegWriteM = 1; #1;
    total++;
    if ({StallD, ForwardAD} !== 2'b01) begin
      bad++; $display("FAIL br_fwd got=%b want=01", {StallD, ForwardAD});
    end
    BranchD = 0; RegWriteE = 1; WriteRegE = 3; #1;
    total++;
    if (StallD !== 1'b0) begin bad++; $display("FAIL br_nobranch got=%b want=0", StallD); end
    $display("test_branch_stall done");
  endtask

  task automatic test_mdu();
    clear_inputs();
    step();
    MduStartD = 1; #1;
    total++;
    if ({StallD, MduBusy} !== 2'b00) begin
      bad++; $display("FAIL mdu_start_idle got=%b want=00", {StallD, MduBusy});
    end
    step();
    MduStartD = 0; MduReadD = 1;
    for (int c = 1; c <= LAT + 2; c++) begin
      logic [2:0] want;
      #1;
      if (c <= LAT)          want = 3'b101;
      else if (c == LAT + 1) want = 3'b011;
      else                   want = 3'b000;
      total++;
      if ({MduBusy, MduDone, StallD} !== want) begin
        bad++; $display("FAIL mdu_cycle%0d busy_done_stall got=%b want=%b", c, {MduBusy, MduDone, StallD}, want);
      end
      if (c < LAT + 2) step();
    end
    MduReadD = 0;
    $display("test_mdu done");
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    MduStartD = 1; #1;
    step();
    MduStartD = 0;
    for (int c = 1; c < LAT + 1; c++) step();
    MduStartD = 1; #1;
    total++;
    if ({MduDone, StallD} !== 2'b11) begin
      bad++; $display("FAIL b2b_done_stall got=%b want=11", {MduDone, StallD});
    end
    step();
    total++;
    if ({MduBusy, MduDone, StallD} !== 3'b000) begin
      bad++; $display("FAIL b2b_idle got=%b want=000", {MduBusy, MduDone, StallD});
    end
    step();
    MduStartD = 0; #1;
    total++;
    if (MduBusy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b want=1", MduBusy); end
    // Start blocked by a load stall must leave the FSM idle.
    for (int c = 0; c < LAT + 1; c++) step();
    MduStartD = 1; MemtoRegE = 1; RtE = 6; RsD = 6;
    step();
    MduStartD = 0; MemtoRegE = 0; #1;
    total++;
    if (MduBusy !== 1'b0) begin bad++; $display("FAIL start_blocked got=%b want=0", MduBusy); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_abort();
    logic saw_done;
    clear_inputs();
    MduStartD = 1; #1;
    step();
    MduStartD = 0;
    step();
    reset = 1'b1; #1;
    total++;
    if (MduBusy !== 1'b0) begin bad++; $display("FAIL abort_async got=%b want=0", MduBusy); end
    step();
    reset = 1'b0;
    MduReadD = 1;
    saw_done = 1'b0;
    for (int c = 0; c < LAT + 2; c++) begin
      #1;
      if (MduDone) saw_done = 1'b1;
      step();
    end
    total++;
    if ({saw_done, StallD} !== 2'b00) begin
      bad++; $display("FAIL abort_no_done got=%b want=00", {saw_done, StallD});
    end
    MduReadD = 0;
    $display("test_reset_abort done");
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    logic [CNT_W-1:0] exp_seq [5];
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    clear_inputs();
    reset = 1'b1; #1;
    total++;
    if ({LoadStallCnt, BranchStallCnt, MduStallCnt} !== '0) begin
      bad++; $display("FAIL perf_reset got=%h want=0", {LoadStallCnt, BranchStallCnt, MduStallCnt});
    end
    reset = 1'b0;
    MemtoRegE = 1; RtE = 8; RsD = 8;
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (LoadStallCnt !== exp_seq[c]) begin
        bad++; $display("FAIL perf_lw%0d got=%0d want=%0d", c, LoadStallCnt, exp_seq[c]);
      end
    end
    total++;
    if ({BranchStallCnt, MduStallCnt} !== '0) begin
      bad++; $display("FAIL perf_other got=%h want=0", {BranchStallCnt, MduStallCnt});
    end
    clear_inputs();
    $display("test_perf done");
  endtask
`endif

  initial begin
    clear_inputs();
    reset = 1'b0;
    test_reset();
    test_forward();
    test_load_stall();
    test_branch_stall();
    test_mdu();
    test_back_to_back();
    test_reset_abort();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
